// File: rtl/rst_req_pkg.sv
// Shared constants for the reset request initiator: cause codes, FSM states
// and register bit positions.
package rst_req_pkg;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_EXT  = 2'd1;
  localparam logic [1:0] CAUSE_WD   = 2'd2;
  localparam logic [1:0] CAUSE_SW   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PULSE        = 2'd1,
    ST_WAIT_ASSERT  = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } state_t;

  localparam int SW_REQ_BIT = 31;
  localparam int ARMED_BIT  = 24;
  localparam int CAUSE_LSB  = 16;

  // Priority external > watchdog > software when several fire together.
  function automatic logic [1:0] pick_cause(input logic ext_f, input logic wd_f,
                                            input logic sw_f);
    if (ext_f)     return CAUSE_EXT;
    else if (wd_f) return CAUSE_WD;
    else if (sw_f) return CAUSE_SW;
    else           return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/rst_req_sync_fall.sv
// Two-flop synchronizer plus falling-edge detector for active-low buttons.
// All flops reset to 1 so releasing reset never produces a spurious edge.
module sync_fall (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_fall = r_s3 & ~r_s2;

endmodule

// File: rtl/rst_req.sv
// Reset request initiator: button, watchdog and software sources produce one
// fixed-width active-low pulse. Watchdog present only with RST_REQ_WATCHDOG_EN.
module rst_req
  import rst_req_pkg::*;
#(
  parameter int PULSE_CYCLES = 16,
  parameter int WD_WIDTH     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sys_rst,
  input  logic        ext_req_n,
  input  logic        tick,
  input  logic        wr,
  input  logic        rd,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        rst_req_n,
  output logic [1:0]  cause
);

  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_n;
  logic [7:0]  r_pulse_cnt;
  logic [7:0]  w_pulse_cnt_n;
  logic [1:0]  r_cause;
  logic [1:0]  w_cause_n;
  logic        r_rst_req_n;

  logic        w_ext_fire;
  logic        w_sw_fire;
  logic        w_wd_fire;
  logic        w_armed;
  logic [15:0] w_wd_cnt16;
  logic        w_unused;

  sync_fall u_sync_ext (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (ext_req_n),
    .o_fall  (w_ext_fire)
  );

  assign w_sw_fire = wr & wdata[SW_REQ_BIT];
  assign w_unused  = ^{tick, wdata};

`ifdef RST_REQ_WATCHDOG_EN
  logic [WD_WIDTH-1:0] r_wd_cnt;
  logic                r_armed;
  logic                w_wd_load;

  // A register write is the kick and takes precedence over a same-cycle tick.
  assign w_wd_load = wr & ~wdata[SW_REQ_BIT];
  assign w_wd_fire = tick & r_armed & ~sys_rst & ~w_wd_load &
                     (r_wd_cnt == WD_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
      r_armed  <= 1'b0;
    end else if (sys_rst) begin
      r_wd_cnt <= '0;
      r_armed  <= 1'b0;
    end else if (w_wd_load) begin
      r_wd_cnt <= wdata[WD_WIDTH-1:0];
      r_armed  <= |wdata[WD_WIDTH-1:0];
    end else if (tick && r_armed) begin
      if (r_wd_cnt == WD_WIDTH'(1)) begin
        r_wd_cnt <= '0;
        r_armed  <= 1'b0;
      end else begin
        r_wd_cnt <= r_wd_cnt - WD_WIDTH'(1);
      end
    end
  end

  assign w_armed    = r_armed;
  assign w_wd_cnt16 = 16'(r_wd_cnt);
`else
  assign w_wd_fire  = 1'b0;
  assign w_armed    = 1'b0;
  assign w_wd_cnt16 = 16'd0;
`endif

  always_comb begin
    w_state_n     = r_state;
    w_pulse_cnt_n = r_pulse_cnt;
    w_cause_n     = r_cause;
    unique case (r_state)
      ST_IDLE: begin
        w_pulse_cnt_n = 8'd0;
        if (w_ext_fire || w_wd_fire || w_sw_fire) begin
          w_state_n = ST_PULSE;
          w_cause_n = pick_cause(w_ext_fire, w_wd_fire, w_sw_fire);
        end
      end
      ST_PULSE: begin
        if (r_pulse_cnt == PULSE_LAST) w_state_n = ST_WAIT_ASSERT;
        else                           w_pulse_cnt_n = r_pulse_cnt + 8'd1;
      end
      ST_WAIT_ASSERT: begin
        if (sys_rst) w_state_n = ST_WAIT_RELEASE;
      end
      ST_WAIT_RELEASE: begin
        if (!sys_rst) w_state_n = ST_IDLE;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // rst_req_n is registered from the next state so the pulse is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pulse_cnt <= 8'd0;
      r_cause     <= CAUSE_NONE;
      r_rst_req_n <= 1'b1;
    end else begin
      r_state     <= w_state_n;
      r_pulse_cnt <= w_pulse_cnt_n;
      r_cause     <= w_cause_n;
      r_rst_req_n <= (w_state_n != ST_PULSE);
    end
  end

  // Bus: wr/rd are single-cycle strobes, acked combinationally in the same
  // cycle (zero wait states); rdata is valid only while rd is high.
  assign ack       = wr | rd;
  assign rdata     = rd ? {7'b0, w_armed, 6'b0, r_cause, w_wd_cnt16} : 32'd0;
  assign rst_req_n = r_rst_req_n;
  assign cause     = r_cause;

endmodule
